abro_input_conditioner: RTL and testbench

Front-end conditioner for the ABRO state machine's A and B inputs (clk/reset_n/A/B in, O/state out). It takes asynchronous, bouncy push-button levels `a_raw` and `b_raw` and synchronises them into `clk`. It debounces each one and emits a clean one-cycle rising-edge pulse per press. Its `a_pulse`/`b_pulse` outputs drive the state machine's A/B ports directly, so the machine only ever sees glitch-free, clock-aligned single-cycle events.

---
 rtl/abro_pkg.sv | 5 +
 rtl/abro_debounce_chan.sv | 41 ++++
 rtl/abro_input_conditioner.sv | 23 ++
 tb/tb_abro_input_conditioner.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/abro_pkg.sv
// abro_pkg: shared constants for the ABRO input conditioner
package abro_pkg;
  localparam int ABRO_DEBOUNCE_DEFAULT = 4;
  localparam int ABRO_SYNC_STAGES = 2;
endpackage

// File: rtl/abro_debounce_chan.sv
// abro_debounce_chan: synchronise, debounce and rising-edge-pulse one raw button level
module abro_debounce_chan
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [ABRO_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, pulse_q, pulse_d, s2, hit;
  always_comb begin
    sync_d = {sync_q[ABRO_SYNC_STAGES-2:0], raw};
    s2 = sync_q[ABRO_SYNC_STAGES-1];
    hit = (s2 != lvl_q) && (cnt_q == CNT_MAX);
    cnt_d = (s2 == lvl_q || hit) ? '0 : cnt_q + 1'b1;
    lvl_d = hit ? s2 : lvl_q;
    pulse_d = hit && s2;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      lvl_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      pulse_q <= pulse_d;
    end
  end
  assign level = lvl_q;
  assign pulse = pulse_q;
endmodule

// File: rtl/abro_input_conditioner.sv
// abro_input_conditioner: two independent debounce channels feeding the ABRO A/B ports
module abro_input_conditioner
  import abro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_level,
  output logic b_level,
  output logic a_pulse,
  output logic b_pulse
);
  abro_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_a (
    .clk(clk), .reset_n(reset_n), .raw(a_raw), .level(a_level), .pulse(a_pulse)
  );
  abro_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_b (
    .clk(clk), .reset_n(reset_n), .raw(b_raw), .level(b_level), .pulse(b_pulse)
  );
endmodule

// File: tb/tb_abro_input_conditioner.sv
// tb_abro_input_conditioner: directed checks of debounce latency, glitch rejection and reset behaviour
module tb_abro_input_conditioner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_level, b_level, a_pulse, b_pulse;
  int tests = 0;
  int fails = 0;

  abro_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .a_raw(a_raw), .b_raw(b_raw),
    .a_level(a_level), .b_level(b_level), .a_pulse(a_pulse), .b_pulse(b_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    step();
    step();
    tests++; if (a_level !== 1'b0) begin fails++; $display("FAIL reset_a_level got %b want 0", a_level); end
    tests++; if (b_level !== 1'b0) begin fails++; $display("FAIL reset_b_level got %b want 0", b_level); end
    tests++; if (a_pulse !== 1'b0) begin fails++; $display("FAIL reset_a_pulse got %b want 0", a_pulse); end
    tests++; if (b_pulse !== 1'b0) begin fails++; $display("FAIL reset_b_pulse got %b want 0", b_pulse); end
    reset_n = 1'b1;
    begin
      int np = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        np += int'(a_pulse) + int'(b_pulse) + int'(a_level) + int'(b_level);
      end
      tests++; if (np != 0) begin fails++; $display("FAIL reset_idle activity got %0d want 0", np); end
    end
  endtask

  task automatic test_clean_press();
    a_raw = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    tests++; if (a_pulse !== 1'b0) begin fails++; $display("FAIL press_early_pulse got %b want 0", a_pulse); end
    step();
    tests++; if (a_pulse !== 1'b1) begin fails++; $display("FAIL press_pulse got %b want 1", a_pulse); end
    tests++; if (a_level !== 1'b1) begin fails++; $display("FAIL press_level got %b want 1", a_level); end
    tests++; if (b_level !== 1'b0 || b_pulse !== 1'b0) begin fails++; $display("FAIL press_b_quiet got %b%b want 00", b_level, b_pulse); end
    step();
    tests++; if (a_pulse !== 1'b0) begin fails++; $display("FAIL press_pulse_width got %b want 0", a_pulse); end
    tests++; if (a_level !== 1'b1) begin fails++; $display("FAIL press_level_hold got %b want 1", a_level); end
    a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    tests++; if (a_level !== 1'b0) begin fails++; $display("FAIL press_release_level got %b want 0", a_level); end
  endtask

  task automatic test_glitch();
    int np;
    np = 0;
    a_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); np += int'(a_pulse) + int'(a_level); end
    a_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); np += int'(a_pulse) + int'(a_level); end
    tests++; if (np != 0) begin fails++; $display("FAIL glitch3_rejected got %0d want 0", np); end
    np = 0;
    a_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); np += int'(a_pulse); end
    a_raw = 1'b0;
    for (int i = 0; i < 14; i++) begin step(); np += int'(a_pulse); end
    tests++; if (np != 1) begin fails++; $display("FAIL glitch4_pulses got %0d want 1", np); end
    tests++; if (a_level !== 1'b0) begin fails++; $display("FAIL glitch4_release got %b want 0", a_level); end
  endtask

  task automatic test_bounce();
    logic [5:0] seq;
    int np, at;
    seq = 6'b101101;
    np = 0;
    at = -1;
    for (int e = 0; e < 22; e++) begin
      a_raw = (e < 6) ? seq[5-e] : 1'b1;
      step();
      if (a_pulse === 1'b1) begin np++; at = e; end
    end
    tests++; if (np != 1) begin fails++; $display("FAIL bounce_pulses got %0d want 1", np); end
    tests++; if (at != 10) begin fails++; $display("FAIL bounce_pulse_edge got %0d want 10", at); end
    a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_simultaneous();
    int np;
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tests++; if (a_pulse !== 1'b1 || b_pulse !== 1'b1) begin fails++; $display("FAIL simul_pulses got %b%b want 11", a_pulse, b_pulse); end
    step();
    tests++; if (a_pulse !== 1'b0 || b_pulse !== 1'b0) begin fails++; $display("FAIL simul_pulse_width got %b%b want 00", a_pulse, b_pulse); end
    a_raw = 1'b0;
    b_raw = 1'b0;
    np = 0;
    for (int i = 0; i < 5; i++) begin step(); np += int'(a_pulse) + int'(b_pulse); end
    tests++; if (a_level !== 1'b1 || b_level !== 1'b1) begin fails++; $display("FAIL simul_release_early got %b%b want 11", a_level, b_level); end
    step();
    np += int'(a_pulse) + int'(b_pulse);
    tests++; if (a_level !== 1'b0 || b_level !== 1'b0) begin fails++; $display("FAIL simul_release_level got %b%b want 00", a_level, b_level); end
    tests++; if (np != 0) begin fails++; $display("FAIL simul_release_pulses got %0d want 0", np); end
  endtask

  task automatic test_reset_mid_count();
    int np;
    a_raw = 1'b1;
    for (int i = 0; i < 3; i++) step();
    #1 reset_n = 1'b0;
    #1;
    tests++; if (a_level !== 1'b0 || a_pulse !== 1'b0) begin fails++; $display("FAIL midrst_outputs got %b%b want 00", a_level, a_pulse); end
    step();
    step();
    reset_n = 1'b1;
    np = 0;
    for (int i = 0; i < 5; i++) begin step(); np += int'(a_pulse) + int'(a_level); end
    tests++; if (np != 0) begin fails++; $display("FAIL midrst_early got %0d want 0", np); end
    step();
    tests++; if (a_pulse !== 1'b1 || a_level !== 1'b1) begin fails++; $display("FAIL midrst_pulse got %b%b want 11", a_pulse, a_level); end
    a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    #2;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
